// File: rtl/shared_buf_fifo_ctrl_pkg.sv
//==============================================================================
// Package  : sb_pkg
// Contents : Shared-buffer FIFO controller defaults, depth helper and the
//            first-word-fall-through state encoding.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

package sb_pkg;

   localparam int c_ADDR_WIDTH_DEF = 4;

   function automatic int sb_depth(input int aw);
      return 1 << aw;
   endfunction

   typedef enum logic [1:0] {
      FWFT_EMPTY    = 2'd0,
      FWFT_PREFETCH = 2'd1,
      FWFT_VALID    = 2'd2
   } fwft_state_t;

endpackage

`default_nettype wire

// File: rtl/shared_buf_fifo_ctrl_ptr_cnt.sv
//==============================================================================
// Module   : sb_ptr_cnt
// Purpose  : Wrapping RAM address pointer with synchronous reset and
//            increment enable.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module sb_ptr_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_ptr
);

   localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= r_ptr + c_one;
      end
   end

   assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/shared_buf_fifo_ctrl.sv
//==============================================================================
// Module   : shared_buf_fifo_ctrl
// Purpose  : Pointer/flag controller for one dual-port FIFO RAM with a
//            registered, read-enable-gated read port. Define SB_FIFO_FWFT_EN
//            for first-word-fall-through behaviour.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module shared_buf_fifo_ctrl
   import sb_pkg::*;
#(
   parameter int ADDR_WIDTH = c_ADDR_WIDTH_DEF,
   parameter int AFULL_TH   = sb_depth(ADDR_WIDTH) - 2,
   parameter int AEMPTY_TH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_req,
   input  logic                  rd_req,
   output logic [ADDR_WIDTH-1:0] ram_wr_ptr,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_ptr,
   output logic                  ram_rd_en,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  wr_ovf,
   output logic                  rd_unf
);

   localparam int                c_depth_i   = sb_depth(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] c_depth   = c_depth_i[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_afull   = AFULL_TH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_aempty  = AEMPTY_TH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_cnt_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0] r_count;
   logic [ADDR_WIDTH:0] w_count_nxt;
   logic                r_full;
   logic                r_empty;
   logic                r_afull;
   logic                r_aempty;
   logic                r_wr_ovf;
   logic                r_rd_unf;
   logic                w_wr_acc;
   logic                w_rd_fetch;
   logic                w_rd_pop;
   logic                w_rd_unf;

   // Full is the registered flag, so a same-cycle read never frees room for a write.
   assign w_wr_acc = wr_req & ~r_full;

`ifdef SB_FIFO_FWFT_EN
   fwft_state_t r_state;
   fwft_state_t w_state_nxt;

   // The head word counts as stored, so more than one word means an unfetched one exists.
   assign w_rd_pop   = rd_req & (r_state == FWFT_VALID);
   assign w_rd_fetch = (r_state == FWFT_PREFETCH) | (w_rd_pop & (r_count > c_cnt_one));
   assign w_rd_unf   = rd_req & (r_state != FWFT_VALID);
   assign rd_valid   = (r_state == FWFT_VALID);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FWFT_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FWFT_EMPTY: begin
            if (w_count_nxt != '0) begin
               w_state_nxt = FWFT_PREFETCH;
            end
         end
         FWFT_PREFETCH: begin
            w_state_nxt = FWFT_VALID;
         end
         FWFT_VALID: begin
            if (w_rd_pop && !w_rd_fetch) begin
               w_state_nxt = FWFT_EMPTY;
            end
         end
         default: begin
            w_state_nxt = FWFT_EMPTY;
         end
      endcase
   end
`else
   logic r_rd_valid;

   // Empty excludes this cycle's write, so a word is never read in the cycle it lands.
   assign w_rd_fetch = rd_req & ~r_empty;
   assign w_rd_pop   = w_rd_fetch;
   assign w_rd_unf   = rd_req & r_empty;
   assign rd_valid   = r_rd_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_fetch;
      end
   end
`endif

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_acc, w_rd_pop})
         2'b10:   w_count_nxt = r_count + c_cnt_one;
         2'b01:   w_count_nxt = r_count - c_cnt_one;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
         r_wr_ovf <= 1'b0;
         r_rd_unf <= 1'b0;
      end else begin
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == c_depth);
         r_empty  <= (w_count_nxt == '0);
         r_afull  <= (w_count_nxt >= c_afull);
         r_aempty <= (w_count_nxt <= c_aempty);
         r_wr_ovf <= wr_req & r_full;
         r_rd_unf <= w_rd_unf;
      end
   end

   sb_ptr_cnt #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_wr_acc),
      .o_ptr (ram_wr_ptr)
   );

   sb_ptr_cnt #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_rd_fetch),
      .o_ptr (ram_rd_ptr)
   );

   assign ram_wr_en    = w_wr_acc;
   assign ram_rd_en    = w_rd_fetch;
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign count        = r_count;
   assign wr_ovf       = r_wr_ovf;
   assign rd_unf       = r_rd_unf;

endmodule

`default_nettype wire

// File: tb/tb_shared_buf_fifo_ctrl.sv
//==============================================================================
// Module   : tb_shared_buf_fifo_ctrl
// Purpose  : Bench for shared_buf_fifo_ctrl with a dual-port RAM and a
//            queue-based reference model (SB_FIFO_FWFT_EN selects FWFT steps).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_shared_buf_fifo_ctrl;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_req = 1'b0;
   logic          rd_req = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic [AW-1:0] ram_wr_ptr;
   logic          ram_wr_en;
   logic [AW-1:0] ram_rd_ptr;
   logic          ram_rd_en;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          wr_ovf;
   logic          rd_unf;

   logic [7:0]    mem [DEPTH];
   logic [7:0]    ram_rdata;

   int            checks   = 0;
   int            failures = 0;

   logic [7:0]    q[$];
   int            m_wr_tot = 0;
   int            m_rd_tot = 0;
   logic [7:0]    m_dout   = 8'h00;

   always #5 clk = ~clk;

   shared_buf_fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_req       (wr_req),
      .rd_req       (rd_req),
      .ram_wr_ptr   (ram_wr_ptr),
      .ram_wr_en    (ram_wr_en),
      .ram_rd_ptr   (ram_rd_ptr),
      .ram_rd_en    (ram_rd_en),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .wr_ovf       (wr_ovf),
      .rd_unf       (rd_unf)
   );

   // Dual-port RAM: registered read gated by read enable, old data on collision.
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_ptr] <= wr_data;
      if (ram_rd_en) ram_rdata <= mem[ram_rd_ptr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input bit vld, input bit ovf, input bit unf);
      int n;
      n = q.size();
      chk("count",        count, n);
      chk("full",         full, n == DEPTH);
      chk("empty",        empty, n == 0);
      chk("almost_full",  almost_full, n >= DEPTH - 2);
      chk("almost_empty", almost_empty, n <= 2);
      chk("rd_valid",     rd_valid, vld);
      if (vld) chk("rd_data", ram_rdata, m_dout);
      chk("wr_ovf",       wr_ovf, ovf);
      chk("rd_unf",       rd_unf, unf);
   endtask

   // One clock of stimulus in standard mode, checked against the queue model.
   task automatic step(input bit wr, input bit rd, input logic [7:0] d);
      int n;
      bit acc_w;
      bit acc_r;
      wr_req  = wr;
      rd_req  = rd;
      wr_data = d;
      #1;
      n     = q.size();
      acc_w = wr && (n < DEPTH);
      acc_r = rd && (n > 0);
      chk("ram_wr_en",  ram_wr_en, acc_w);
      chk("ram_rd_en",  ram_rd_en, acc_r);
      chk("ram_wr_ptr", ram_wr_ptr, m_wr_tot % DEPTH);
      chk("ram_rd_ptr", ram_rd_ptr, m_rd_tot % DEPTH);
      @(posedge clk);
      if (acc_r) m_dout = q.pop_front();
      if (acc_w) q.push_back(d);
      m_wr_tot += int'(acc_w);
      m_rd_tot += int'(acc_r);
      #1;
      check_regs(acc_r, wr && (n == DEPTH), rd && (n == 0));
   endtask

   // Reset with both requests active so any in-flight read would show up as stale.
   task automatic do_reset();
      rst    = 1'b1;
      wr_req = 1'b1;
      rd_req = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      wr_req = 1'b0;
      rd_req = 1'b0;
      q.delete();
      m_wr_tot = 0;
      m_rd_tot = 0;
      #1;
      check_regs(1'b0, 1'b0, 1'b0);
      chk("rst_wr_en",  ram_wr_en, 1'b0);
      chk("rst_rd_en",  ram_rd_en, 1'b0);
      chk("rst_wr_ptr", ram_wr_ptr, 0);
      chk("rst_rd_ptr", ram_rd_ptr, 0);
   endtask

   initial begin
      do_reset();

`ifdef SB_FIFO_FWFT_EN
      wr_req  = 1'b1;
      wr_data = 8'h5A;
      @(posedge clk);
      #1;
      wr_req = 1'b0;
      chk("fwft_cnt_n1",   count, 1);
      chk("fwft_vld_n1",   rd_valid, 1'b0);
      chk("fwft_rden_n1",  ram_rd_en, 1'b1);
      @(posedge clk);
      #1;
      chk("fwft_vld_n2",   rd_valid, 1'b1);
      chk("fwft_data_n2",  ram_rdata, 8'h5A);
      chk("fwft_empty_n2", empty, 1'b0);
      rd_req = 1'b1;
      #1;
      chk("fwft_rden_pop", ram_rd_en, 1'b0);
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      chk("fwft_vld_n3",   rd_valid, 1'b0);
      chk("fwft_empty_n3", empty, 1'b1);
      chk("fwft_cnt_n3",   count, 0);
      do_reset();
`else
      repeat (3) step(1'b0, 1'b0, 8'h00);

      // Fill to full, then one dropped write.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i));
      step(1'b1, 1'b0, 8'hAA);

      // Drain in order, then one read of an empty FIFO.
      for (int i = 0; i <= DEPTH; i++) step(1'b0, 1'b1, 8'h00);

      // Half fill, then steady-state streaming across the pointer wrap.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h20 + 8'(i));
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'h40 + 8'(i));
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);

      // Write and read together on an empty FIFO: no bypass.
      step(1'b1, 1'b1, 8'h77);
      step(1'b0, 1'b1, 8'h00);

      // Random traffic, biased first towards filling and then towards draining.
      for (int i = 0; i < 150; i++)
         step(($urandom % 4) != 0, ($urandom % 4) == 0, 8'($urandom));
      for (int i = 0; i < 150; i++)
         step(($urandom % 4) == 0, ($urandom % 4) != 0, 8'($urandom));
      for (int i = 0; i < 150; i++)
         step(1'($urandom), 1'($urandom), 8'($urandom));

      // Reset in mid-stream at count 5 with a read in flight.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h90 + 8'(i));
      step(1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 8'h95);
      do_reset();
      step(1'b0, 1'b0, 8'h00);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
